// File: rtl/incoming_event_sched_pkg.sv
// Shared definitions for the incoming event scheduler and the per-flow user logic:
// default widths, packet type codes, and the packed event / context layouts.
package incoming_event_sched_pkg;

    localparam int DEF_FLOW_ID_W = 10;
    localparam int DEF_EV_W      = 96;
    localparam int DEF_CTX_W     = 256;
    localparam int DEF_SEQ_W     = 32;

    // Packet type codes carried in the top byte of an event.
    typedef enum logic [7:0] {
        PKT_ACK  = 8'h01,
        PKT_NACK = 8'h02
    } pkt_type_e;

    // Event layout, MSB first (96 bits).
    typedef struct packed {
        pkt_type_e   pkt_type;
        logic [23:0] sack_tx_id;
        logic [31:0] sack;
        logic [31:0] cum_ack;
    } ev_t;

    // Per-flow context layout, MSB first (256 bits).
    typedef struct packed {
        logic [127:0] user;
        logic [31:0]  timer;
        logic [31:0]  snd_una;
        logic [31:0]  snd_nxt;
        logic [31:0]  cwnd;
    } ctx_t;

endpackage

// File: rtl/incoming_event_sched_ctx_hold_reg.sv
// Stage-B context source: the memory read data is only valid on B's first
// cycle, so a stalled B keeps a private copy and presents that instead.
module ctx_hold_reg #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         first,
    input  logic         capture,
    input  logic         advance,
    input  logic [W-1:0] rd_data,
    output logic [W-1:0] ctx
);

    logic [W-1:0] hold_q;
    logic         held_q;

    // Capture read data when B stalls on its first cycle; drop it once B moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            held_q <= 1'b0;
        end else if (capture) begin
            hold_q <= rd_data;
            held_q <= 1'b1;
        end else if (advance) begin
            held_q <= 1'b0;
        end
    end

    assign ctx = first ? rd_data : (held_q ? hold_q : '0);

endmodule

// File: rtl/incoming_event_sched.sv
// Incoming ACK/NACK event scheduler: Issue (context read), Exec (user logic),
// Commit (context write + retransmit request). Same-flow events are held at
// issue while an older event of that flow is still in Exec or Commit, so the
// context read always sees the last committed write.
module incoming_event_sched
    import incoming_event_sched_pkg::*;
#(
    parameter int FLOW_ID_W = DEF_FLOW_ID_W,
    parameter int EV_W      = DEF_EV_W,
    parameter int CTX_W     = DEF_CTX_W,
    parameter int SEQ_W     = DEF_SEQ_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ev_valid,
    output logic                 ev_ready,
    input  logic [FLOW_ID_W-1:0] ev_flow_id,
    input  logic [EV_W-1:0]      ev_data,
    output logic                 ctx_rd_en,
    output logic [FLOW_ID_W-1:0] ctx_rd_addr,
    input  logic [CTX_W-1:0]     ctx_rd_data,
    output logic                 udl_valid,
    output logic [EV_W-1:0]      udl_event,
    output logic [CTX_W-1:0]     udl_ctx,
    input  logic [CTX_W-1:0]     udl_ctx_new,
    input  logic                 udl_mark_rtx,
    input  logic [SEQ_W-1:0]     udl_rtx_start,
    input  logic [SEQ_W-1:0]     udl_rtx_end,
    output logic                 ctx_wr_en,
    output logic [FLOW_ID_W-1:0] ctx_wr_addr,
    output logic [CTX_W-1:0]     ctx_wr_data,
    output logic                 rtx_valid,
    input  logic                 rtx_ready,
    output logic [FLOW_ID_W-1:0] rtx_flow_id,
    output logic [SEQ_W-1:0]     rtx_start,
    output logic [SEQ_W-1:0]     rtx_end,
    output logic                 busy,
    output logic [31:0]          events_done
);

    // Exec stage
    logic                 b_valid;
    logic                 b_first;
    logic [FLOW_ID_W-1:0] b_flow;
    logic [EV_W-1:0]      b_event;

    // Commit stage
    logic                 c_valid;
    logic                 c_mark;
    logic [FLOW_ID_W-1:0] c_flow;
    logic [CTX_W-1:0]     c_ctx;
    logic [SEQ_W-1:0]     c_rtx_start;
    logic [SEQ_W-1:0]     c_rtx_end;

    logic [31:0]          ev_cnt_q;

    logic hazard;
    logic accept;
    logic b_adv;
    logic c_ret;

    assign c_ret  = c_valid & (!c_mark | rtx_ready);
    assign b_adv  = b_valid & (!c_valid | c_ret);
    assign hazard = (b_valid && (b_flow == ev_flow_id)) ||
                    (c_valid && (c_flow == ev_flow_id));
    // rst_n gates ready so nothing is accepted while reset is held.
    assign ev_ready = rst_n & !hazard & (!b_valid | b_adv);
    assign accept   = ev_valid & ev_ready;

    assign ctx_rd_en   = accept;
    assign ctx_rd_addr = ev_flow_id;

    // Issue -> Exec: register the accepted event; b_first marks the read-data cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid <= 1'b0;
            b_first <= 1'b0;
            b_flow  <= '0;
            b_event <= '0;
        end else begin
            b_first <= accept;
            if (accept) begin
                b_valid <= 1'b1;
                b_flow  <= ev_flow_id;
                b_event <= ev_data;
            end else if (b_adv) begin
                b_valid <= 1'b0;
            end
        end
    end

    ctx_hold_reg #(
        .W (CTX_W)
    ) u_ctx_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .first   (b_first),
        .capture (b_valid & b_first & !b_adv),
        .advance (b_adv),
        .rd_data (ctx_rd_data),
        .ctx     (udl_ctx)
    );

    assign udl_valid = b_valid;
    assign udl_event = b_event;

    // Exec -> Commit: capture user-logic results; the write strobe fires only on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_valid     <= 1'b0;
            c_mark      <= 1'b0;
            c_flow      <= '0;
            c_ctx       <= '0;
            c_rtx_start <= '0;
            c_rtx_end   <= '0;
            ctx_wr_en   <= 1'b0;
        end else begin
            ctx_wr_en <= b_adv;
            if (b_adv) begin
                c_valid     <= 1'b1;
                c_mark      <= udl_mark_rtx;
                c_flow      <= b_flow;
                c_ctx       <= udl_ctx_new;
                c_rtx_start <= udl_rtx_start;
                c_rtx_end   <= udl_rtx_end;
            end else if (c_ret) begin
                c_valid <= 1'b0;
            end
        end
    end

    // Retired-event counter, free-running modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_cnt_q <= '0;
        end else if (c_ret) begin
            ev_cnt_q <= ev_cnt_q + 32'd1;
        end
    end

    assign ctx_wr_addr = c_flow;
    assign ctx_wr_data = c_ctx;
    assign rtx_valid   = c_valid & c_mark;
    assign rtx_flow_id = c_flow;
    assign rtx_start   = c_rtx_start;
    assign rtx_end     = c_rtx_end;
    assign busy        = b_valid | c_valid;
    assign events_done = ev_cnt_q;

endmodule

// File: doc/incoming_event_sched.md
Name: incoming_event_sched

Overview:
- Sequences ACK/NACK events from the receive path through the per-flow incoming user logic.
- Per event:
  - reads the flow context from context memory;
  - presents event plus context to the combinational user-logic port;
  - writes the updated context back;
  - forwards retransmit ranges to the retransmit queue.
- 3-stage pipeline (Issue/Exec/Commit) with same-flow hazard blocking, so a flow's context is never read stale.

Parameters:
FLOW_ID_W, 10, flow index width (1024 flows)
EV_W, 96, packed event width (pkt type, cumulative ack, selective ack, sack tx id)
CTX_W, 256, packed per-flow context width (window, timers, user context)
SEQ_W, 32, sequence number width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ev_valid  in  1  incoming event valid
ev_ready  out  1  event accepted when ev_valid & ev_ready
ev_flow_id  in  FLOW_ID_W  event flow
ev_data  in  EV_W  packed event
ctx_rd_en  out  1  context read strobe; data returns next cycle
ctx_rd_addr  out  FLOW_ID_W  read address
ctx_rd_data  in  CTX_W  read data, valid cycle after ctx_rd_en
udl_valid  out  1  user-logic inputs valid
udl_event  out  EV_W  event to user logic
udl_ctx  out  CTX_W  current context to user logic
udl_ctx_new  in  CTX_W  updated context, combinational same cycle
udl_mark_rtx  in  1  user logic requests retransmit
udl_rtx_start  in  SEQ_W  rtx range start (inclusive)
udl_rtx_end  in  SEQ_W  rtx range end (exclusive)
ctx_wr_en  out  1  context write strobe
ctx_wr_addr  out  FLOW_ID_W  write address
ctx_wr_data  out  CTX_W  write data
rtx_valid  out  1  retransmit request valid
rtx_ready  in  1  retransmit queue ready
rtx_flow_id  out  FLOW_ID_W  flow to retransmit
rtx_start  out  SEQ_W  range start
rtx_end  out  SEQ_W  range end
busy  out  1  any stage valid
events_done  out  32  retired-event count, wraps mod 2^32

Behaviour:
Clock and reset
- Single clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset clears:
  - all stage valids and the hold register flag;
  - all registered outputs, events_done and ctx_wr_en to 0.
- ev_ready is 0 while rst_n is low.
- Reset mid-operation discards in-flight events: no write and no rtx request for them afterwards.

Issue (A)
- ev_ready = !hazard & (!B_valid | B_adv).
- hazard = (B_valid & B_flow == ev_flow_id) | (C_valid & C_flow == ev_flow_id).
- On accept: ctx_rd_en=1, ctx_rd_addr=ev_flow_id; flow and event registered into B; B_valid=1 next cycle.

Exec (B)
- udl_valid = B_valid; udl_event = B_event.
- udl_ctx = ctx_rd_data on B's first cycle, otherwise the hold register.
- If B does not advance on its first cycle, ctx_rd_data is captured into the hold register.
- B_adv = B_valid & (!C_valid | C_ret).
- On B_adv, registered into C:
  - udl_ctx_new;
  - udl_mark_rtx;
  - rtx start/end;
  - flow id.

Commit (C)
- Entry cycle: ctx_wr_en=1 for exactly one cycle with C_flow / C_ctx.
- rtx_valid = C_valid & C_mark, held stable until rtx_ready.
- C_ret = C_valid & (!C_mark | rtx_ready).
- events_done increments on C_ret.
- Writes are never repeated while C stalls.

Throughput and latency
- Distinct flows: 1 event/cycle.
- Same flow back-to-back: one every 3 cycles.
- Accept to ctx_wr_en is 2 cycles.
- Memory read-during-write returns old data; the hazard rule covers this.
- busy = B_valid | C_valid.

Decomposition:
- Event field offsets, context layout offsets and pkt type codes (ACK/NACK) go in user_constants.vh, shared with the user logic.
- One sub-module, ctx_hold_reg: a first-cycle bypass/hold mux for the stage-B read data.

Test Plan:
1. Reset, then three events to flows 1, 2, 3 on consecutive cycles, no rtx:
   - ev_ready stays 1;
   - ctx_wr_en on cycles 2, 3, 4 with addrs 1, 2, 3;
   - events_done = 3.
2. Two events to flow 5 back-to-back:
   - ev_ready = 0 for 2 cycles;
   - second read issued after the first write;
   - second udl_ctx equals the first udl_ctx_new.
3. NACK to flow 7 with udl_mark_rtx=1, start=100, end=101, rtx_ready=0 for 4 cycles:
   - rtx_valid held with stable fields;
   - exactly one ctx_wr_en;
   - next event (flow 8) stalls in B with udl_ctx from the hold register;
   - everything retires after rtx_ready=1.
4. Flow 9 accepted while flow 9 is in C:
   - blocked until C retires;
   - a flow 10 event in the same window is accepted immediately.
5. Assert rst_n low with B and C valid:
   - all outputs 0 immediately;
   - no ctx_wr_en or rtx_valid after release;
   - events_done = 0.
6. Preload events_done to 0xFFFFFFFF, retire one event -> events_done = 0.
